// File: rtl/dbg_cmd_pkg.sv
// Shared types for the debug command sequencer: command opcodes, response
// status codes, FSM states and the timeout counter width.
package dbg_cmd_pkg;

  // Width of the access timeout counter; covers the full TIMEOUT range.
  localparam int TMO_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b10,
    ST_ERR     = 2'b11
  } rsp_status_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } seq_state_e;

  // True for opcodes that start a bus transaction.
  function automatic logic op_is_access(input cmd_op_e op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

  // True for any opcode that counts as a real command (overrun candidate).
  function automatic logic op_is_cmd(input cmd_op_e op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/dbg_timeout_ctr.sv
// Access timeout counter for the debug command sequencer. Held at zero while
// clr is high, counts while en is high, and flags expire once the count has
// reached TIMEOUT-1 (it then holds). Used only when DBG_CMD_SEQ_TIMEOUT_EN
// is defined.
module dbg_timeout_ctr
  import dbg_cmd_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic tck,
  input  logic trst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(TIMEOUT - 1);

  logic [TMO_CNT_W-1:0] cnt;

  // Cycle counter: cleared outside an access, saturates at the expiry count.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/dbg_cmd_seq.sv
// Debug command sequencer (JTAG clock domain). Takes one command per
// Update-DR pulse, runs it as a single req/ack access on the core debug bus
// and holds status/data for the next Capture-DR. Commands arriving while an
// access is in flight are dropped and flagged in the sticky overrun bit.
// Build option: DBG_CMD_SEQ_TIMEOUT_EN adds an access timeout of TIMEOUT
// cycles; without it an access waits for bus_ack/bus_err indefinitely.
module dbg_cmd_seq
  import dbg_cmd_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              rsp_capture,
  output logic              cmd_busy,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              rsp_overrun,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [DATA_W-1:0] bus_rdata
);

  seq_state_e state;
  cmd_op_e    op;
  logic       tmo_expire;

  assign op = cmd_op_e'(cmd_op);

`ifdef DBG_CMD_SEQ_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  assign tmo_clr = (state == S_IDLE);
  assign tmo_en  = (state == S_ACCESS);

  dbg_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .tck    (tck),
    .trst   (trst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );
`else
  // No timeout: only a bus response (or trst) ends an access.
  logic unused_timeout;

  assign tmo_expire     = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Sequencer FSM: launches accesses, holds bus outputs, records results.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state      <= S_IDLE;
      cmd_busy   <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (op_is_access(op)) begin
              bus_req   <= 1'b1;
              cmd_busy  <= 1'b1;
              bus_we    <= (op == OP_WRITE);
              bus_addr  <= cmd_addr;
              bus_wdata <= cmd_wdata;
              state     <= S_ACCESS;
            end else if (op == OP_RSVD) begin
              rsp_status <= ST_ERR;
            end
          end
        end
        S_ACCESS: begin
          // Error beats a simultaneous ack; any response beats the timeout.
          if (bus_err) begin
            rsp_status <= ST_ERR;
            bus_req    <= 1'b0;
            cmd_busy   <= 1'b0;
            state      <= S_IDLE;
          end else if (bus_ack) begin
            rsp_status <= ST_OK;
            if (!bus_we) begin
              rsp_data <= bus_rdata;
            end
            bus_req  <= 1'b0;
            cmd_busy <= 1'b0;
            state    <= S_IDLE;
          end else if (tmo_expire) begin
            rsp_status <= ST_TIMEOUT;
            bus_req    <= 1'b0;
            cmd_busy   <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: set by a command during an access, cleared by capture;
  // a set in the same cycle as a capture keeps the flag high.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      rsp_overrun <= 1'b0;
    end else if (cmd_valid && op_is_cmd(op) && (state == S_ACCESS)) begin
      rsp_overrun <= 1'b1;
    end else if (rsp_capture) begin
      rsp_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dbg_cmd_seq.sv
// Testbench for dbg_cmd_seq: directed commands, expected results queued in a
// scoreboard and checked by a monitor when cmd_busy falls.
module tb_dbg_cmd_seq;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              tck = 1'b0;
  logic              trst;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_capture;
  logic              cmd_busy;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_status;
  logic              rsp_overrun;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic              bus_err;
  logic [DATA_W-1:0] bus_rdata;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] data;
    int          busy;   // expected cmd_busy high cycles, 0 = not checked
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_failed = 0;

  dbg_cmd_seq #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .tck         (tck),
    .trst        (trst),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_capture (rsp_capture),
    .cmd_busy    (cmd_busy),
    .rsp_data    (rsp_data),
    .rsp_status  (rsp_status),
    .rsp_overrun (rsp_overrun),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_err     (bus_err),
    .bus_rdata   (bus_rdata)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic respond(input logic ack, input logic err, input logic [31:0] rd);
    bus_ack   = ack;
    bus_err   = err;
    bus_rdata = rd;
    tick();
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
  endtask

  // Monitor: on each completed access compare against the scoreboard head.
  initial begin
    int   busy_cnt;
    logic prev;
    exp_t e;
    busy_cnt = 0;
    prev     = 1'b0;
    forever begin
      @(negedge tck);
      if (trst !== 1'b1) begin
        busy_cnt = 0;
        prev     = 1'b0;
      end else begin
        if (cmd_busy === 1'b1) begin
          busy_cnt++;
        end else if (prev) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("sb_status", {30'd0, rsp_status}, {30'd0, e.st});
            chk("sb_data", rsp_data, e.data);
            if (e.busy != 0) chk("sb_busy_cycles", busy_cnt, e.busy);
          end
          busy_cnt = 0;
        end
        prev = (cmd_busy === 1'b1);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    trst        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    rsp_capture = 1'b0;
    bus_ack     = 1'b0;
    bus_err     = 1'b0;
    bus_rdata   = '0;
    tick();
    tick();

    // Reset state
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_cmd_busy", {31'd0, cmd_busy}, 32'd0);
    chk("rst_status", {30'd0, rsp_status}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_overrun", {31'd0, rsp_overrun}, 32'd0);
    chk("rst_bus_addr_we", {23'd0, bus_we, bus_addr}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    trst = 1'b1;
    tick();

    // Reset in the middle of an access
    issue(2'b01, 8'h20, 32'h0);
    chk("midrst_req_before", {31'd0, bus_req}, 32'd1);
    trst = 1'b0;
    #1;
    chk("midrst_req", {31'd0, bus_req}, 32'd0);
    chk("midrst_busy", {31'd0, cmd_busy}, 32'd0);
    chk("midrst_addr", {24'd0, bus_addr}, 32'd0);
    tick();
    tick();
    trst = 1'b1;
    tick();

    // READ 0x10, ack one cycle after bus_req rises
    sb.push_back('{st: 2'b00, data: 32'hDEADBEEF, busy: 2});
    issue(2'b01, 8'h10, 32'h0);
    chk("rd_addr", {24'd0, bus_addr}, 32'h10);
    chk("rd_we", {31'd0, bus_we}, 32'd0);
    tick();
    respond(1'b1, 1'b0, 32'hDEADBEEF);
    chk("rd_req_low", {31'd0, bus_req}, 32'd0);

    // WRITE with ack and err together: err wins, data unchanged
    sb.push_back('{st: 2'b11, data: 32'hDEADBEEF, busy: 2});
    issue(2'b10, 8'h04, 32'h12345678);
    chk("wr_we", {31'd0, bus_we}, 32'd1);
    chk("wr_addr", {24'd0, bus_addr}, 32'h04);
    tick();
    chk("wr_wdata_held", bus_wdata, 32'h12345678);
    chk("wr_we_held", {31'd0, bus_we}, 32'd1);
    respond(1'b1, 1'b1, 32'hFFFF0000);

`ifdef DBG_CMD_SEQ_TIMEOUT_EN
    // READ with no response: timeout after exactly TIMEOUT cycles
    sb.push_back('{st: 2'b10, data: 32'hDEADBEEF, busy: 4});
    issue(2'b01, 8'h30, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_req === 1'b1) n++;
      tick();
    end
    chk("tmo_req_cycles", n, 32'd4);
    chk("tmo_status", {30'd0, rsp_status}, 32'h2);

    // Ack on the last allowed cycle beats the timeout
    sb.push_back('{st: 2'b00, data: 32'hCAFEF00D, busy: 4});
    issue(2'b01, 8'h31, 32'h0);
    tick();
    tick();
    tick();
    respond(1'b1, 1'b0, 32'hCAFEF00D);
    chk("tmo_ack_status", {30'd0, rsp_status}, 32'h0);
`else
    // Without the timeout the access waits for its response
    sb.push_back('{st: 2'b00, data: 32'hCAFEF00D, busy: 11});
    issue(2'b01, 8'h30, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_req === 1'b1) n++;
      tick();
    end
    chk("notmo_req_cycles", n, 32'd10);
    respond(1'b1, 1'b0, 32'hCAFEF00D);
    chk("notmo_status", {30'd0, rsp_status}, 32'h0);
`endif

    // Overrun: second WRITE dropped, capture vs. set, capture alone
    sb.push_back('{st: 2'b00, data: 32'hCAFEF00D, busy: 4});
    issue(2'b10, 8'h08, 32'h00000055);
    issue(2'b10, 8'h0C, 32'h000000AA);
    chk("ovr_set", {31'd0, rsp_overrun}, 32'd1);
    chk("ovr_addr_kept", {24'd0, bus_addr}, 32'h08);
    chk("ovr_wdata_kept", bus_wdata, 32'h55);
    rsp_capture = 1'b1;
    issue(2'b10, 8'h0C, 32'h000000AA);
    chk("ovr_cap_and_set", {31'd0, rsp_overrun}, 32'd1);
    tick();
    rsp_capture = 1'b0;
    chk("ovr_cap_clear", {31'd0, rsp_overrun}, 32'd0);
    respond(1'b1, 1'b0, 32'h99999999);

    // NOP during an access is not an overrun
    sb.push_back('{st: 2'b00, data: 32'h13579BDF, busy: 2});
    issue(2'b01, 8'h40, 32'h0);
    issue(2'b00, 8'h41, 32'h0);
    chk("nop_no_ovr", {31'd0, rsp_overrun}, 32'd0);
    respond(1'b1, 1'b0, 32'h13579BDF);

    // Reserved op in IDLE: no access, status ERR next cycle
    issue(2'b11, 8'h50, 32'h0);
    chk("rsvd_no_req", {31'd0, bus_req}, 32'd0);
    chk("rsvd_no_busy", {31'd0, cmd_busy}, 32'd0);
    chk("rsvd_status", {30'd0, rsp_status}, 32'h3);

    // Responses while IDLE are ignored
    respond(1'b1, 1'b0, 32'h77777777);
    chk("idle_ack_status", {30'd0, rsp_status}, 32'h3);
    chk("idle_ack_data", rsp_data, 32'h13579BDF);

    // NOP in IDLE changes nothing
    issue(2'b00, 8'h60, 32'h0);
    chk("idle_nop_req", {31'd0, bus_req}, 32'd0);
    chk("idle_nop_status", {30'd0, rsp_status}, 32'h3);

    tick();
    tick();
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_seq.md
# dbg_cmd_seq

Debug command sequencer in the JTAG clock domain of the Debug Access Port. Accepts one command per JTAG Update-DR from the debug-port data register, runs it as a single request/acknowledge transaction on the core debug bus, and holds the result and status for the next Capture-DR. It serialises host commands onto the core debug resource, rejects overlapping commands, and bounds each access with a timeout.

## Interface
Parameters:
- ADDR_W, 8, core debug bus address width
- DATA_W, 32, core debug bus data width
- TIMEOUT, 255, cycles bus_req may stay high without response (legal range 2..65535)

Ports:
- tck  input  1  test clock; all state on rising edge
- trst  input  1  test reset, asynchronous, active-low
- cmd_valid  input  1  one-cycle pulse on Update-DR
- cmd_op  input  2  00 NOP, 01 READ, 10 WRITE, 11 reserved
- cmd_addr  input  ADDR_W  target register address
- cmd_wdata  input  DATA_W  write data
- rsp_capture  input  1  one-cycle pulse on Capture-DR; clears sticky overrun
- cmd_busy  output  1  transaction in flight
- rsp_data  output  DATA_W  last read data
- rsp_status  output  2  00 OK, 01 reserved, 10 TIMEOUT, 11 ERR
- rsp_overrun  output  1  sticky: command arrived while busy
- bus_req  output  1  core debug bus request
- bus_we  output  1  1 = write
- bus_addr  output  ADDR_W  bus address
- bus_wdata  output  DATA_W  bus write data
- bus_ack  input  1  access completed
- bus_err  input  1  access failed
- bus_rdata  input  DATA_W  read data, valid with bus_ack

## Operation
- Reset (trst low, asynchronous): state IDLE; every output 0, rsp_status 00.
- FSM states: IDLE, ACCESS.
- IDLE + cmd_valid, op READ/WRITE: register addr, wdata, we (1 for WRITE); bus_req = 1, cmd_busy = 1; go ACCESS; timeout counter = 0.
- IDLE + cmd_valid, op NOP: ignored, no state change.
- IDLE + cmd_valid, op 11: no bus access; rsp_status = 11 next cycle; stay IDLE.
- ACCESS: bus_req, bus_we, bus_addr, bus_wdata held stable until exit.
- ACCESS + bus_err: rsp_status = 11, rsp_data unchanged, go IDLE. bus_err wins over simultaneous bus_ack.
- ACCESS + bus_ack (no err): rsp_status = 00; READ loads rsp_data = bus_rdata; WRITE leaves rsp_data unchanged; go IDLE.
- ACCESS, no response: counter increments; at counter == TIMEOUT-1 with no response → rsp_status = 10, go IDLE. Response in that same cycle wins over timeout.
- cmd_valid (any op except NOP) while ACCESS: command dropped, rsp_overrun = 1. Transaction in flight unaffected.
- rsp_capture clears rsp_overrun; a simultaneous overrun set wins (stays 1).
- bus_ack/bus_err ignored in IDLE.

## Timing
- cmd_valid at cycle N → bus_req, bus_addr, bus_we, bus_wdata, cmd_busy high/valid from N+1.
- Response sampled at cycle M (M ≥ N+1) → bus_req and cmd_busy low, rsp_data and rsp_status updated at M+1. Minimum command-to-result latency 2 cycles.
- A new cmd_valid is accepted in cycle M+1.
- Timeout: bus_req high for exactly TIMEOUT cycles, status 10 visible the following cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- DBG_CMD_SEQ_TIMEOUT_EN defined: timeout counter present, behaviour as above.
- Not defined: counter and TIMEOUT check removed; ACCESS waits indefinitely for bus_ack/bus_err; status 10 never produced; only trst recovers a hung bus.

## Structure
- Package dbg_cmd_pkg: cmd_op enum (NOP, READ, WRITE, RSVD), rsp_status enum (OK, TIMEOUT, ERR), FSM state enum, status encodings.
- Sub-module dbg_timeout_ctr: clear, enable, expire flag at TIMEOUT-1; instantiated only under DBG_CMD_SEQ_TIMEOUT_EN.

## Test plan
- Reset mid-ACCESS (trst low with bus_req high) → all outputs 0 immediately, IDLE; next READ proceeds normally.
- READ addr 0x10, bus_ack one cycle after bus_req with rdata 0xDEADBEEF → rsp_data 0xDEADBEEF, rsp_status 00, cmd_busy high exactly 2 cycles.
- WRITE addr 0x04 data 0x12345678, bus_ack and bus_err asserted together → bus_we 1, bus_wdata 0x12345678 held; rsp_status 11; rsp_data unchanged.
- READ, no response, TIMEOUT=4 → bus_req high exactly 4 cycles, rsp_status 10; bus_ack on 4th cycle instead → status 00.
- Second WRITE during ACCESS → dropped, rsp_overrun 1; rsp_capture coincident with another overrun → stays 1; rsp_capture alone → clears to 0.
- Op 11 in IDLE → no bus_req, rsp_status 11 next cycle; NOP in ACCESS → no overrun.
